// File: rtl/key_conditioner_if.sv
// Key bundle between the board push-buttons and the conditioner.
// key_n: raw active-low pins; pulse: one-cycle press strobes; level: debounced pressed state.
interface key_if #(
   parameter int NKEYS = 3
);
   logic [NKEYS-1:0] key_n;
   logic [NKEYS-1:0] pulse;
   logic [NKEYS-1:0] level;

   modport master (output key_n, input pulse, input level);
   modport slave  (input key_n, output pulse, output level);
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes, debounces and edge-detects active-low push-buttons,
// producing a one-cycle press pulse per debounced press.
// Optional hold-to-repeat per key is built only when KEY_AUTOREPEAT_EN is defined;
// without it every key yields exactly one pulse per debounced press.
// Key index: 0 = undo, 1 = move, 2 = scramble.
//
// Repeat FSM (one per key with REPEAT_MASK bit set):
//   state      | meaning
//   IDLE       | key released (or mask clear); rcnt held at 0
//   WAIT_FIRST | pressed, counting REPEAT_DELAY to the first repeat pulse
//   REPEATING  | still held, firing a pulse every REPEAT_PERIOD cycles
// A debounced release returns to IDLE from any state without firing.
module key_conditioner #(
   parameter int               NKEYS           = 3,
   parameter int               DEBOUNCE_CYCLES = 1_000_000,
   parameter int               REPEAT_DELAY    = 25_000_000,
   parameter int               REPEAT_PERIOD   = 5_000_000,
   parameter logic [NKEYS-1:0] REPEAT_MASK     = 3'b001
) (
   input  logic  clk,
   input  logic  rst,
   key_if.slave  keys
);

   localparam int             DW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   // Elaboration-time parameter sanity; these never produce hardware.
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2");
   end
   if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
      $error("key_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
   end

   logic [NKEYS-1:0] sync1;
   logic [NKEYS-1:0] s;
   logic [NKEYS-1:0] level_q;
   logic [NKEYS-1:0] level_d;
   logic [NKEYS-1:0] rise;
   logic [NKEYS-1:0] rep_fire;
   logic [NKEYS-1:0] pulse_q;

   // Two-flop synchronizer on the inverted pins so s[k] = 1 means pressed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         s     <= '0;
      end else begin
         sync1 <= ~keys.key_n;
         s     <= sync1;
      end
   end

   for (genvar k = 0; k < NKEYS; k++) begin : g_db
      logic [DW-1:0] cnt;
      logic          lvl;

      // Debounce: level follows s only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt <= '0;
            lvl <= 1'b0;
         end else if (s[k] == lvl) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            lvl <= s[k];
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign level_q[k] = lvl;
   end

   assign rise = level_q & ~level_d;

   // Edge-detect history and the registered press/repeat strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= '0;
         pulse_q <= '0;
      end else begin
         level_d <= level_q;
         pulse_q <= rise | rep_fire;
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int            RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                         : REPEAT_PERIOD;
   localparam int            RW          = $clog2(RMAX);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FIRST,
      REPEATING
   } rep_state_t;

   logic [NKEYS-1:0] fall;
   assign fall = ~level_q & level_d;

   for (genvar k = 0; k < NKEYS; k++) begin : g_rep
      if (REPEAT_MASK[k]) begin : g_on
         rep_state_t    state;
         rep_state_t    state_nxt;
         logic [RW-1:0] rcnt;
         logic [RW-1:0] rcnt_nxt;
         logic          fire;

         // Repeat FSM state and interval counter.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state <= IDLE;
               rcnt  <= '0;
            end else begin
               state <= state_nxt;
               rcnt  <= rcnt_nxt;
            end
         end

         // Next state and repeat strobe; a release wins over a due repeat.
         always_comb begin
            state_nxt = state;
            rcnt_nxt  = rcnt + 1'b1;
            fire      = 1'b0;
            if (fall[k]) begin
               state_nxt = IDLE;
               rcnt_nxt  = '0;
            end else begin
               case (state)
                  IDLE: begin
                     rcnt_nxt = '0;
                     if (rise[k]) state_nxt = WAIT_FIRST;
                  end
                  WAIT_FIRST: begin
                     if (rcnt == DELAY_LAST) begin
                        state_nxt = REPEATING;
                        rcnt_nxt  = '0;
                        fire      = 1'b1;
                     end
                  end
                  REPEATING: begin
                     if (rcnt == PERIOD_LAST) begin
                        rcnt_nxt = '0;
                        fire     = 1'b1;
                     end
                  end
                  default: begin
                     state_nxt = IDLE;
                     rcnt_nxt  = '0;
                  end
               endcase
            end
         end

         assign rep_fire[k] = fire;
      end else begin : g_off
         assign rep_fire[k] = 1'b0;
      end
   end
`else
   assign rep_fire = '0;
`endif

   assign keys.pulse = pulse_q;
   assign keys.level = level_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a pulse scoreboard.
// Expected pulses (cycle number, key mask) are queued as keys are driven;
// a negedge monitor pops and compares every non-zero pulse it sees.
module tb_key_conditioner;
   localparam int NK = 3;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   key_if #(.NKEYS(NK)) keys ();

   key_conditioner #(
      .NKEYS          (NK),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP),
      .REPEAT_MASK    (3'b001)
   ) dut (
      .clk (clk),
      .rst (rst),
      .keys(keys.slave)
   );

   typedef struct {
      int            at;
      logic [NK-1:0] mask;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && keys.pulse !== '0) begin
         if (exp_q.size() == 0) begin
            checks++;
            assert (keys.pulse === 3'b000) else begin
               errors++;
               $error("FAIL unexpected_pulse cyc=%0d got %b exp %b", cyc, keys.pulse, 3'b000);
            end
         end else begin
            e = exp_q.pop_front();
            checks++;
            assert (cyc === e.at) else begin
               errors++;
               $error("FAIL pulse_time got cyc=%0d exp cyc=%0d (mask %b)", cyc, e.at, e.mask);
            end
            checks++;
            assert (keys.pulse === e.mask) else begin
               errors++;
               $error("FAIL pulse_mask cyc=%0d got %b exp %b", cyc, keys.pulse, e.mask);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int at, input logic [NK-1:0] m);
      exp_t e;
      e.at   = at;
      e.mask = m;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got %b exp %b", tag, cyc, got, exp);
      end
   endtask

   task automatic chk_drained(input string tag);
      checks++;
      assert (exp_q.size() === 0) else begin
         errors++;
         $error("FAIL %s pending_pulses got %0d exp 0", tag, exp_q.size());
      end
   endtask

   initial begin : stim
      int c;
      int r;
      int offs[7];
      offs = '{10, 13, 16, 19, 22, 25, 28};

      // Reset with all keys released.
      rst        = 1'b1;
      keys.key_n = '1;
      tick(3);
      chk("reset_level", keys.level, 3'b000);
      chk("reset_pulse", keys.pulse, 3'b000);
      rst    = 1'b0;
      mon_en = 1'b1;
      tick(3);
      chk("idle_level", keys.level, 3'b000);

      // Clean press on move: level rises at edge c+6, pulse seen at c+7, none on release.
      c             = cyc;
      keys.key_n[1] = 1'b0;
      push(c + 7, 3'b010);
      tick(5);
      chk("press_level_before", keys.level, 3'b000);
      tick(1);
      chk("press_level_rise", keys.level, 3'b010);
      tick(14);
      keys.key_n[1] = 1'b1;
      tick(5);
      chk("release_level_before", keys.level, 3'b010);
      tick(1);
      chk("release_level_fall", keys.level, 3'b000);
      tick(4);
      chk_drained("clean_press");

      // Bounce on scramble: 3 low / 1 high never survives debounce.
      for (int i = 0; i < 5; i++) begin
         keys.key_n[2] = 1'b0;
         for (int j = 0; j < 3; j++) begin
            tick(1);
            chk("bounce_level", keys.level, 3'b000);
         end
         keys.key_n[2] = 1'b1;
         tick(1);
         chk("bounce_level", keys.level, 3'b000);
      end
      tick(8);
      chk("bounce_final_level", keys.level, 3'b000);
      chk_drained("bounce");

      // Auto-repeat on undo: level stays high 30 cycles (edges c+6..c+36).
      c             = cyc;
      keys.key_n[0] = 1'b0;
      push(c + 7, 3'b001);
`ifdef KEY_AUTOREPEAT_EN
      foreach (offs[i]) push(c + 7 + offs[i], 3'b001);
`endif
      tick(30);
      keys.key_n[0] = 1'b1;
      tick(12);
      chk("repeat_release_level", keys.level, 3'b000);
      chk_drained("autorepeat");

      // Move is not in the repeat mask: one pulse over a 40-cycle hold.
      c             = cyc;
      keys.key_n[1] = 1'b0;
      push(c + 7, 3'b010);
      tick(40);
      chk("norepeat_level", keys.level, 3'b010);
      keys.key_n[1] = 1'b1;
      tick(10);
      chk("norepeat_release", keys.level, 3'b000);
      chk_drained("non_repeat");

      // Simultaneous press of all keys: one pulse word with every bit set.
      c          = cyc;
      keys.key_n = '0;
      push(c + 7, 3'b111);
      tick(6);
      chk("simul_level", keys.level, 3'b111);
      tick(2);
      keys.key_n = '1;
      tick(10);
      chk("simul_release", keys.level, 3'b000);
      chk_drained("simultaneous");

      // Reset while undo is repeating, key held throughout.
      c             = cyc;
      keys.key_n[0] = 1'b0;
      push(c + 7, 3'b001);
`ifdef KEY_AUTOREPEAT_EN
      push(c + 17, 3'b001);
      push(c + 20, 3'b001);
`endif
      tick(21);
      rst = 1'b1;
      #1;
      chk("midreset_level", keys.level, 3'b000);
      chk("midreset_pulse", keys.pulse, 3'b000);
      tick(1);
      chk("midreset_level2", keys.level, 3'b000);
      chk("midreset_pulse2", keys.pulse, 3'b000);
      tick(1);
      chk_drained("pre_reset_repeats");
      rst = 1'b0;
      r   = cyc;
      push(r + 7, 3'b001);
`ifdef KEY_AUTOREPEAT_EN
      push(r + 17, 3'b001);
      push(r + 20, 3'b001);
      push(r + 23, 3'b001);
`endif
      tick(5);
      chk("postreset_level_before", keys.level, 3'b000);
      tick(1);
      chk("postreset_level_rise", keys.level, 3'b001);
      tick(13);
      keys.key_n[0] = 1'b1;
      tick(12);
      chk("postreset_release", keys.level, 3'b000);
      chk_drained("reset_mid_hold");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
